// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer driven by a mid-bit center_tick,
// with a valid/ready byte output and framing/overrun error pulses.
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 center_tick,
    output logic                 phase_arm,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int CW = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state, w_next;
    logic                 r_sync1, r_sync2, r_prev;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic [CW-1:0]        r_cnt;
    logic                 r_valid, r_ferr, r_oerr;
    logic                 w_fall, w_last, w_stop_tick, w_load;

    assign w_fall      = r_prev && !r_sync2;
    assign w_last      = r_cnt == CW'(DATA_BITS - 1);
    assign w_stop_tick = (r_state == STOP) && center_tick;
    assign w_load      = w_stop_tick && r_sync2;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_fall ? START : IDLE;
            START:   w_next = center_tick ? (r_sync2 ? IDLE : DATA) : START;
            DATA:    w_next = (center_tick && w_last) ? STOP : DATA;
            STOP:    w_next = center_tick ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            if (r_state == START && center_tick)
                r_cnt <= '0;
            if (r_state == DATA && center_tick) begin
                r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_load)
                r_data <= r_shift;
            // A load wins over a same-cycle consume, so valid stays high.
            r_valid <= w_load ? 1'b1 : ((r_valid && rx_ready) ? 1'b0 : r_valid);
            r_ferr  <= w_stop_tick && !r_sync2;
            r_oerr  <= w_load && r_valid && !rx_ready;
        end
    end

    assign phase_arm   = r_state == IDLE;
    assign busy        = r_state != IDLE;
    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_ferr;
    assign overrun_err = r_oerr;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: drives 8N1 frames through a 16x phase counter model and
// scoreboards received bytes and error pulses against a frame-level model.
module tb_uart_rx_ctrl;
    logic       clk = 0;
    logic       rst_n, rx_in, rx_ready;
    logic       phase_arm, rx_valid, frame_err, overrun_err, busy;
    logic [7:0] rx_data;
    logic [3:0] ph;
    logic       center_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    logic [1:0] exp_flags[$];
    logic       m_pending = 0;
    logic [7:0] m_data = 0;
    logic       prev_hs = 0;

    uart_rx_ctrl #(.DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .center_tick(center_tick),
        .phase_arm(phase_arm), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Oversampling phase counter: held at zero while armed, strobes mid-bit.
    always @(posedge clk) ph <= phase_arm ? 4'd0 : ph + 4'd1;
    assign center_tick = !phase_arm && ph == 4'd7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err || overrun_err) begin
                if (exp_flags.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flag_unexpected actual fe=%0b ov=%0b expected none", frame_err, overrun_err);
                end else
                    chk("flag", {30'd0, frame_err, overrun_err}, {30'd0, exp_flags.pop_front()});
            end
            if (rx_valid && rx_ready) begin
                if (prev_hs) begin
                    checks++;
                    errors++;
                    $display("FAIL valid_pulse actual=2+ cycles expected=1 cycle");
                end
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected actual=%0h expected none", rx_data);
                end else
                    chk("byte", {24'd0, rx_data}, {24'd0, exp_bytes.pop_front()});
            end
        end
        prev_hs = rst_n && rx_valid && rx_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (16) tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic set_ready(input logic v);
        if (v && m_pending) begin
            exp_bytes.push_back(m_data);
            m_pending = 0;
        end
        rx_ready = v;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (m_pending && !rx_ready)
                exp_flags.push_back(2'b01);
            m_data = b;
            if (rx_ready)
                exp_bytes.push_back(b);
            else
                m_pending = 1;
        end else
            exp_flags.push_back(2'b10);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_phase_arm"}, {31'd0, phase_arm}, 32'd1);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_flags"}, {30'd0, frame_err, overrun_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rb;
        logic       st;
        rst_n = 0;
        rx_in = 1;
        rx_ready = 1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1;
        idle(2);

        send(8'hA5, 1'b1);
        chk("a5_phase_arm", {31'd0, phase_arm}, 32'd1);
        chk("a5_busy", {31'd0, busy}, 32'd0);
        idle(1);

        rx_in = 0;
        repeat (3) tick();
        rx_in = 1;
        repeat (3) tick();
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        idle(2);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);

        send(8'h3C, 1'b0);
        idle(1);
        chk("ferr_valid", {31'd0, rx_valid}, 32'd0);
        chk("ferr_data", {24'd0, rx_data}, {24'd0, m_data});

        set_ready(1'b0);
        send(8'h11, 1'b1);
        chk("ovr_first_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_first_data", {24'd0, rx_data}, 32'h11);
        send(8'h22, 1'b1);
        chk("ovr_second_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_second_data", {24'd0, rx_data}, 32'h22);
        idle(1);
        set_ready(1'b1);
        idle(1);

        v = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        rx_in = v[4];
        repeat (5) tick();
        rst_n = 0;
        #1;
        chk_reset_outputs("midreset");
        m_pending = 0;
        m_data = 0;
        repeat (2) tick();
        rst_n = 1;
        idle(2);
        send(8'h5A, 1'b1);
        idle(1);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom);
            st = $urandom_range(0, 5) != 0;
            if ($urandom_range(0, 2) == 0)
                set_ready(1'($urandom_range(0, 1)));
            send(rb, st);
            idle(st ? $urandom_range(0, 2) : $urandom_range(1, 2));
        end
        set_ready(1'b1);
        idle(2);

        chk("bytes_left", exp_bytes.size(), 32'd0);
        chk("flags_left", exp_flags.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side frame sequencer for the UART RX path.
- Synchronises the serial line and detects the start-bit edge.
- Arms and releases the oversampling phase counter, then uses its mid-bit center_tick to sample start, data and stop bits.
- Presents each received byte on a valid/ready handshake and reports framing and overrun errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first; legal range 5..9.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_in  input  1  raw serial line, asynchronous to clk, idle high
- center_tick  input  1  one-cycle mid-bit strobe from the phase counter
- phase_arm  output  1  holds the phase counter at zero while high
- rx_data  output  DATA_BITS  last accepted byte
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: a new byte overwrote an unconsumed byte
- busy  output  1  high in any state other than IDLE

Behaviour:
Reset (async, rst_n=0):
- State IDLE; phase_arm=1; rx_data=0; rx_valid=0; frame_err=0; overrun_err=0; busy=0.
- Both synchroniser flops and the previous-sample flop reset to 1.
- Shift register and bit counter reset to 0.

Synchroniser:
- Two-flop synchroniser on rx_in gives rx_s.
- A third flop gives rx_prev.
- Falling edge = rx_prev==1 && rx_s==0.

phase_arm:
- phase_arm = (state==IDLE), decoded directly from the state register.

State machine:
- IDLE: on falling edge -> START.
- START: on center_tick, if rx_s==0 -> DATA and bit_cnt=0; if rx_s==1 -> IDLE (glitch reject, no error flag).
- DATA: on center_tick, shift rx_s into the MSB of shift_reg (shift right); bit_cnt++. When bit_cnt==DATA_BITS-1 on the tick -> STOP. After DATA_BITS shifts, shift_reg holds the byte LSB-aligned.
- STOP: on center_tick, -> IDLE.
  - If rx_s==1: rx_data<=shift_reg; rx_valid<=1. If rx_valid was already 1 and is not being consumed this cycle, pulse overrun_err for one cycle; the new byte overwrites the old one.
  - If rx_s==0: pulse frame_err for one cycle; byte discarded; rx_data and rx_valid unchanged.
- center_tick outside START, DATA and STOP is ignored.

Handshake and flags:
- Consume: rx_valid && rx_ready -> rx_valid<=0 next cycle.
- Load and consume in the same cycle: rx_valid stays 1, no overrun.
- frame_err and overrun_err are registered and default to 0 every cycle.

Timing:
- rx_valid rises one cycle after the stop-bit center_tick.
- Earliest next-frame start detection is the cycle after IDLE is re-entered, i.e. mid stop bit. Back-to-back frames are supported.

Reset mid-frame:
- All state and outputs return to reset values immediately.
- A frame in progress is dropped silently.

Test Plan:
- Instance with phase counter (OVERSAMPLE=16, baud_en every cycle), 8N1 frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 cycle, frame_err=0, phase_arm=1 after stop center.
- rx_in low for 3 baud ticks then high -> START rejects at center_tick, returns to IDLE, rx_valid=0, frame_err=0, busy falls.
- Frame 0x3C with stop bit driven 0 -> frame_err single-cycle pulse, rx_valid stays 0, rx_data unchanged.
- rx_ready=0; frames 0x11 then 0x22 -> rx_data=0x11 with valid held; at second stop, rx_data=0x22, overrun_err pulses once, rx_valid stays 1.
- rst_n pulsed low mid DATA (bit 4 of 0x96) -> outputs at reset values immediately, no rx_valid; next frame 0x5A received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap, rx_ready=1 -> two valid pulses carrying 0x00 then 0xFF, no errors.
